// File: rtl/colparity_ctrl.sv
// Column-parity (theta C-plane) sequencer: preloads slice NUM_SLICES-1, then walks slices 0..NUM_SLICES-1.
// Optional COLPARITY_STALL_EN adds a `stall` input that holds the WR state.
module colparity_ctrl #(
   parameter int NUM_SLICES = 64,
   parameter int ADDR_W     = 6,
   parameter int MEM_LAT    = 1,
   parameter int IDX_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef COLPARITY_STALL_EN
   input  logic              stall,
`endif
   input  logic [IDX_W-1:0]  file_idx_i,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              ld_cur,
   output logic              ld_prev,
   output logic              write_file,
   output logic [IDX_W-1:0]  file_index,
   output logic              busy,
   output logic              done
);

   // state   | meaning
   // IDLE    | waiting for start
   // PRE_RD  | read slice NUM_SLICES-1 (neighbour of slice 0)
   // PRE_WT  | memory latency wait for preload
   // PRE_CAP | capture preload into current-parity register
   // PRE_SH  | shift preload into previous-parity register, z=0
   // RD      | read slice z
   // WT      | memory latency wait
   // CAP     | capture slice z into current-parity register
   // WR      | write slice z to file, shift current into previous
   // DONE    | one-cycle end-of-frame pulse
   typedef enum logic [3:0] {
      IDLE, PRE_RD, PRE_WT, PRE_CAP, PRE_SH, RD, WT, CAP, WR, DONE
   } state_e;

   localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
   localparam logic [ADDR_W-1:0] LAST_Z    = ADDR_W'(NUM_SLICES - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   z_q, z_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [IDX_W-1:0]    file_index_q, file_index_d;
   logic                stall_hold;

`ifdef COLPARITY_STALL_EN
   assign stall_hold = stall;
`else
   assign stall_hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         z_q          <= '0;
         wait_q       <= '0;
         file_index_q <= '0;
      end else begin
         state_q      <= state_d;
         z_q          <= z_d;
         wait_q       <= wait_d;
         file_index_q <= file_index_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      z_d          = z_q;
      wait_d       = wait_q;
      file_index_d = file_index_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = PRE_RD;
               file_index_d = file_idx_i;
            end
         end
         PRE_RD: begin
            wait_d  = WAIT_LOAD;
            state_d = (MEM_LAT > 1) ? PRE_WT : PRE_CAP;
         end
         PRE_WT: begin
            if (wait_q == '0) state_d = PRE_CAP;
            else              wait_d  = wait_q - 1'b1;
         end
         PRE_CAP: state_d = PRE_SH;
         PRE_SH: begin
            z_d     = '0;
            state_d = RD;
         end
         RD: begin
            wait_d  = WAIT_LOAD;
            state_d = (MEM_LAT > 1) ? WT : CAP;
         end
         WT: begin
            if (wait_q == '0) state_d = CAP;
            else              wait_d  = wait_q - 1'b1;
         end
         CAP: state_d = WR;
         WR: begin
            // terminal compare is on the slice counter, not on the wrapped read address
            if (!stall_hold) begin
               if (z_q == LAST_Z) begin
                  state_d = DONE;
               end else begin
                  z_d     = z_q + 1'b1;
                  state_d = RD;
               end
            end
         end
         DONE: begin
            z_d     = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_rd     = 1'b0;
      mem_addr   = '0;
      ld_cur     = 1'b0;
      ld_prev    = 1'b0;
      write_file = 1'b0;
      done       = 1'b0;
      busy       = (state_q != IDLE);
      unique case (state_q)
         PRE_RD: begin
            mem_rd   = 1'b1;
            mem_addr = LAST_Z;
         end
         RD: begin
            mem_rd   = 1'b1;
            mem_addr = z_q;
         end
         PRE_CAP, CAP: ld_cur = 1'b1;
         PRE_SH:       ld_prev = 1'b1;
         WR: begin
            write_file = !stall_hold;
            ld_prev    = !stall_hold;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign file_index = file_index_q;

endmodule

// File: tb/tb_colparity_ctrl.sv
// Bench for colparity_ctrl: default build (MEM_LAT=1) and a MEM_LAT=3 instance, checked against a
// cycle-position model of the frame (block/offset arithmetic over (NUM_SLICES+1) blocks).
module tb_colparity_ctrl;
   localparam int N = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [9:0] file_idx_i = '0;

   logic       rd_a, cur_a, prev_a, wr_a, busy_a, done_a;
   logic [5:0] addr_a;
   logic [9:0] fidx_a;
   logic       rd_b, cur_b, prev_b, wr_b, busy_b, done_b;
   logic [5:0] addr_b;
   logic [9:0] fidx_b;

   int vectors = 0;
   int miscompares = 0;
   bit sel = 1'b0;

   always #5 clk = ~clk;

   colparity_ctrl #(.NUM_SLICES(N), .ADDR_W(6), .MEM_LAT(1), .IDX_W(10)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .file_idx_i(file_idx_i),
      .mem_rd(rd_a), .mem_addr(addr_a), .ld_cur(cur_a), .ld_prev(prev_a),
      .write_file(wr_a), .file_index(fidx_a), .busy(busy_a), .done(done_a));

   colparity_ctrl #(.NUM_SLICES(N), .ADDR_W(6), .MEM_LAT(3), .IDX_W(10)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .file_idx_i(file_idx_i),
      .mem_rd(rd_b), .mem_addr(addr_b), .ld_cur(cur_b), .ld_prev(prev_b),
      .write_file(wr_b), .file_index(fidx_b), .busy(busy_b), .done(done_b));

   logic       o_rd, o_cur, o_prev, o_wr, o_busy, o_done;
   logic [5:0] o_addr;
   logic [9:0] o_fidx;
   assign o_rd   = sel ? rd_b   : rd_a;
   assign o_cur  = sel ? cur_b  : cur_a;
   assign o_prev = sel ? prev_b : prev_a;
   assign o_wr   = sel ? wr_b   : wr_a;
   assign o_busy = sel ? busy_b : busy_a;
   assign o_done = sel ? done_b : done_a;
   assign o_addr = sel ? addr_b : addr_a;
   assign o_fidx = sel ? fidx_b : fidx_a;

   typedef struct packed {
      logic       rd;
      logic [5:0] addr;
      logic       cur;
      logic       prev;
      logic       wr;
      logic       busy;
      logic       done;
   } exp_t;

   // Frame = N+1 blocks of (lat+2) cycles: block 0 preloads slice N-1, block b>0 handles slice b-1.
   function automatic exp_t model(input int c, input int lat);
      exp_t m;
      int   blk, off, t;
      m   = '0;
      t   = (N + 1) * (lat + 2);
      blk = (c - 1) / (lat + 2);
      off = (c - 1) % (lat + 2);
      if (c >= 1 && c <= t) begin
         m.busy = 1'b1;
         if (off == 0) begin
            m.rd   = 1'b1;
            m.addr = (blk == 0) ? 6'(N - 1) : 6'(blk - 1);
         end
         if (off == lat) m.cur = 1'b1;
         if (off == lat + 1) begin
            m.prev = 1'b1;
            m.wr   = (blk != 0);
         end
      end else if (c == t + 1) begin
         m.busy = 1'b1;
         m.done = 1'b1;
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Called from a negedge with start already driven; the next posedge is the accept edge.
   task automatic frame_check(input int idx, input int mid_idx, input bit keep, input int stop_c);
      exp_t e;
      int   lat, t, last, writes;
      lat    = sel ? 3 : 1;
      t      = (N + 1) * (lat + 2);
      last   = (stop_c != 0) ? stop_c : t + 1;
      writes = 0;
      @(posedge clk);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c == 1 && !keep) drive_start(1'b0);
         if (c == 30 && !keep) drive_start(1'($urandom));
         if (c == 50) file_idx_i = 10'(mid_idx);
         if (c == 100 && !keep) drive_start(1'b0);
         e = model(c, lat);
         if (o_wr) writes++;
         chk("mem_rd", 32'(o_rd), 32'(e.rd));
         chk("mem_addr", 32'(o_addr), 32'(e.addr));
         chk("ld_cur", 32'(o_cur), 32'(e.cur));
         chk("ld_prev", 32'(o_prev), 32'(e.prev));
         chk("write_file", 32'(o_wr), 32'(e.wr));
         chk("busy", 32'(o_busy), 32'(e.busy));
         chk("done", 32'(o_done), 32'(e.done));
         chk("file_index", 32'(o_fidx), 32'(idx));
      end
      if (stop_c == 0) chk("write_count", 32'(writes), 32'(N));
   endtask

   task automatic idle_check(input int cycles, input int idx);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         file_idx_i = 10'($urandom_range(0, 1023));
         chk("idle_busy", 32'(o_busy), 32'd0);
         chk("idle_write", 32'(o_wr), 32'd0);
         chk("idle_fidx", 32'(o_fidx), 32'(idx));
      end
   endtask

   initial begin
      int idx;
      // reset state
      #3;
      sel = 1'b0;
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_rd", 32'(rd_a), 32'd0);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_fidx", 32'(fidx_a), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // basic frame, index 7
      @(negedge clk);
      file_idx_i = 10'd7;
      drive_start(1'b1);
      frame_check(7, $urandom_range(0, 1023), 1'b0, 0);
      drive_start(1'b0);
      idle_check($urandom_range(2, 6), 7);

      // start held through frame, index changed to 9 mid-frame
      @(negedge clk);
      file_idx_i = 10'd7;
      drive_start(1'b1);
      frame_check(7, 9, 1'b1, 0);
      @(negedge clk);
      chk("b2b_idle_busy", 32'(o_busy), 32'd0);
      chk("b2b_idle_fidx", 32'(o_fidx), 32'd7);
      frame_check(9, $urandom_range(0, 1023), 1'b0, 0);
      drive_start(1'b0);
      idle_check(3, 9);

      // random frames
      for (int k = 0; k < 2; k++) begin
         idx = $urandom_range(0, 1023);
         @(negedge clk);
         file_idx_i = 10'(idx);
         drive_start(1'b1);
         frame_check(idx, $urandom_range(0, 1023), 1'b0, 0);
         drive_start(1'b0);
         idle_check($urandom_range(1, 5), idx);
      end

      // MEM_LAT=3 instance
      sel = 1'b1;
      idx = $urandom_range(0, 1023);
      @(negedge clk);
      file_idx_i = 10'(idx);
      drive_start(1'b1);
      frame_check(idx, $urandom_range(0, 1023), 1'b0, 0);
      drive_start(1'b0);
      idle_check(3, idx);

      // async reset in slice 10 WR, then no writes until a new start
      sel = 1'b0;
      idx = $urandom_range(1, 1023);
      @(negedge clk);
      file_idx_i = 10'(idx);
      drive_start(1'b1);
      frame_check(idx, 0, 1'b0, 36);
      chk("pre_rst_wr", 32'(o_wr), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(o_busy), 32'd0);
      chk("arst_wr", 32'(o_wr), 32'd0);
      chk("arst_prev", 32'(o_prev), 32'd0);
      chk("arst_rd", 32'(o_rd), 32'd0);
      chk("arst_addr", 32'(o_addr), 32'd0);
      chk("arst_fidx", 32'(o_fidx), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle_check(40, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
